psi_threshold_stream: RTL
=========================

# psi_threshold_stream

Streaming, threshold-capable successor to the combinational n-party intersection block. Party bit-vectors arrive one W-bit word per cycle over a valid/ready stream. Per-bit occurrence counters accumulate over N parties, and one result word is emitted per chunk, set where at least T parties hold the element. Per-chunk and per-set cardinalities (popcounts) are also reported. It sits between the party input deserialiser and the garbled-circuit output stage, so a universe of W·CHUNKS elements costs W counters instead of N·W·CHUNKS wires.

## Interface
- W, default 32: chunk width in bits (universe slice per result word).
- N, default 4: number of parties (≥2).
- CHUNKS, default 4: chunks per set; universe size = W·CHUNKS.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- thr  in  $clog2(N+1)  threshold T; sampled on acceptance of word 0 of chunk 0.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  W  current party's bits for current chunk.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  result word; bit i = (count_i ≥ T).
- out_count  out  $clog2(W+1)  popcount of out_data.
- total_count  out  $clog2(W·CHUNKS+1)  running set cardinality.
- done  out  1  one-cycle pulse after the last chunk's result handshake.

## Operation
- Word order fixed: chunk 0 party 0..N-1, chunk 1 party 0..N-1, …; party index implicit from party counter.
- T effective: thr==0 or thr>N → T=N (pure intersection). T=1 → union.
- States: ACCUM, EMIT. Reset → ACCUM.
- ACCUM: in_ready=1, out_valid=0. On in_valid&in_ready: cnt_i += in_data[i] for all i; party_ctr++. On word N-1: out_data ← threshold of updated counts, out_count ← its popcount, party_ctr←0, → EMIT.
- EMIT: in_ready=0, out_valid=1, out_data/out_count stable until handshake. On out_valid&out_ready: all cnt_i←0; total_count += out_count; chunk_ctr++ (wraps to 0 after CHUNKS-1); → ACCUM. On handshake of chunk CHUNKS-1: done=1 next cycle.
- Acceptance of word 0 of chunk 0 clears total_count and samples thr. total_count otherwise holds, including after done.
- Counters are $clog2(N+1) wide and never overflow, since at most N increments occur per chunk.
- Reset values: in_ready=1 after reset release; out_valid=0, out_data=0, out_count=0, total_count=0, done=0; all counters 0, T register = N.

## Timing
- Latency: N-th word accepted at edge k → out_valid=1 in cycle k+1.
- Throughput: N+1 cycles per chunk with out_ready held high; N·CHUNKS+CHUNKS cycles per set.
- out_ready low in EMIT: state, outputs and counters hold indefinitely. in_valid is ignored, since in_ready=0.
- in_valid may drop between words of a chunk; partial counts persist.
- done asserts in the cycle after the final handshake. total_count already includes the final chunk in that cycle.
- Reset mid-chunk or mid-EMIT: everything clears asynchronously, partial data is discarded, and the next accepted word is treated as chunk 0 party 0.

## Structure
- Package psi_pkg: width helper functions (CNT_W=$clog2(N+1), PC_W=$clog2(W+1), TOT_W=$clog2(W·CHUNKS+1)) and the state enum {ACCUM, EMIT}.
- Sub-module psi_popcount (parameter W): combinational popcount, instantiated once on the thresholded word.
- Top holds the counter array, FSM, party/chunk counters and output registers.

## Test plan
All scenarios use W=8, N=4, CHUNKS=2, out_ready=1 unless stated.
1. Intersection, thr=0: chunk 0 words 0xFF,0xF0,0x3C,0x30; chunk 1 all 0x01 → out 0x30/2, then 0x01/1; total_count=3; done pulses once.
2. Union, thr=1: chunk words 0x01,0x02,0x04,0x80 → out_data=0x87, out_count=4.
3. Threshold, thr=3: 0x0F,0x33,0x55,0x00 → bit counts {3,2,2,1,2,1,1,0} → out_data=0x01, out_count=1.
4. Backpressure: out_ready low 5 cycles in EMIT → out_data stable, in_ready=0, in_valid asserted meanwhile has no effect; resume → next chunk counts start at 0.
5. Gaps/reset: in_valid toggled between words, giving the same result as scenario 1. Assert rst_n after 2 words of chunk 1 → outputs 0; a fresh set then gives correct results and total_count restarted.
6. thr=7 (>N) with scenario-1 data → identical to intersection results.

Source files
------------

// File: rtl/psi_pkg.sv
// Shared types and width helpers for the streaming threshold intersection block.
package psi_pkg;

    typedef enum logic {
        ACCUM,
        EMIT
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int pc_w(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int tot_w(input int w, input int chunks);
        return $clog2(w * chunks + 1);
    endfunction

endpackage

// File: rtl/psi_popcount.sv
// Combinational population count of a W-bit word.
module psi_popcount
    import psi_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]        data,
    output logic [pc_w(W)-1:0]  count
);

    localparam int PC_W = pc_w(W);

    // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + PC_W'(data[i]);
        end
    end

endmodule

// File: rtl/psi_threshold_stream.sv
// Streaming N-party threshold intersection: per-bit occurrence counters over one
// chunk, a thresholded result word per chunk, and running set cardinality.
module psi_threshold_stream
    import psi_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 4,
    parameter int CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [cnt_w(N)-1:0]           thr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [W-1:0]                  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [W-1:0]                  out_data,
    output logic [pc_w(W)-1:0]            out_count,
    output logic [tot_w(W, CHUNKS)-1:0]   total_count,
    output logic                          done
);

    localparam int CNT_W = cnt_w(N);
    localparam int PC_W  = pc_w(W);
    localparam int TOT_W = tot_w(W, CHUNKS);
    localparam int CH_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q   [W];
    logic [CNT_W-1:0]   cnt_upd [W];
    logic [CNT_W-1:0]   party_q;
    logic [CNT_W-1:0]   thr_q;
    logic [CH_W-1:0]    chunk_q;
    logic [W-1:0]       hit;
    logic [PC_W-1:0]    hit_count;
    logic               accept, handshake;
    logic               last_party, last_chunk, first_word;

    assign accept     = in_valid & in_ready;
    assign handshake  = out_valid & out_ready;
    assign last_party = (party_q == CNT_W'(N - 1));
    assign last_chunk = (chunk_q == CH_W'(CHUNKS - 1));
    assign first_word = (party_q == '0) && (chunk_q == '0);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_party) state_d = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Threshold is compared against the counts including the word being accepted.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            cnt_upd[i] = cnt_q[i] + CNT_W'(in_data[i]);
            hit[i]     = (cnt_upd[i] >= thr_q);
        end
    end

    psi_popcount #(.W(W)) u_popcount (
        .data  (hit),
        .count (hit_count)
    );

    // NOTE: the counter array is reset on purpose: a mid-chunk reset must discard partial counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) cnt_q[i] <= '0;
        end else if (handshake) begin
            for (int i = 0; i < W; i++) cnt_q[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < W; i++) cnt_q[i] <= cnt_upd[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            party_q     <= '0;
            chunk_q     <= '0;
            thr_q       <= CNT_W'(N);
            out_data    <= '0;
            out_count   <= '0;
            total_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= handshake && last_chunk;
            if (accept) begin
                party_q <= last_party ? '0 : party_q + CNT_W'(1);
                if (first_word) begin
                    // Out-of-range or zero thresholds collapse to pure intersection.
                    thr_q       <= (thr == '0 || int'(thr) > N) ? CNT_W'(N) : thr;
                    total_count <= '0;
                end
                if (last_party) begin
                    out_data  <= hit;
                    out_count <= hit_count;
                end
            end
            if (handshake) begin
                total_count <= total_count + TOT_W'(out_count);
                chunk_q     <= last_chunk ? '0 : chunk_q + CH_W'(1);
            end
        end
    end

endmodule
